// File: rtl/pool_stream_reader.sv
// pool_stream_reader: on each rising edge of pool_done, holds the pool stage
// planes stable and streams all NUM_CH x POOL_X x POOL_Y elements downstream
// over valid/ready, channel-major, then row, then column.
module pool_stream_reader #(
  parameter int unsigned DATA_WIDTH = 69,
  parameter int unsigned POOL_X     = 12,
  parameter int unsigned POOL_Y     = 12,
  parameter int unsigned NUM_CH     = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                pool_done,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_1,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_2,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_3,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_4,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_5,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_6,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_7,
  input  logic signed [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] pool_result_8,
  output logic                                                pool_hold,
  output logic signed [DATA_WIDTH-1:0]                        out_data,
  output logic        [2:0]                                   out_ch,
  output logic        [3:0]                                   out_x,
  output logic        [3:0]                                   out_y,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic                                                out_last,
  output logic                                                read_done,
  output logic                                                read_abort
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  logic [1:0]                                   state;
  logic                                         pool_done_q;
  logic [POOL_X-1:0][POOL_Y-1:0][DATA_WIDTH-1:0] planes [8];
  logic [2:0]                                   nxt_ch;
  logic [3:0]                                   nxt_x;
  logic [3:0]                                   nxt_y;
  logic [DATA_WIDTH-1:0]                        nxt_data;
  logic                                         start;
  logic                                         handshake;
  logic                                         at_end;

  assign planes[0] = pool_result_1;
  assign planes[1] = pool_result_2;
  assign planes[2] = pool_result_3;
  assign planes[3] = pool_result_4;
  assign planes[4] = pool_result_5;
  assign planes[5] = pool_result_6;
  assign planes[6] = pool_result_7;
  assign planes[7] = pool_result_8;

  assign start     = pool_done && !pool_done_q;
  assign handshake = out_valid && out_ready;
  assign at_end    = (out_ch == 3'(NUM_CH - 1)) && (out_x == 4'(POOL_X - 1)) &&
                     (out_y == 4'(POOL_Y - 1));
  assign out_last  = out_valid && at_end;
  assign nxt_data  = planes[nxt_ch][nxt_x][nxt_y];

  // Next coordinate: column fastest, then row, then channel.
  always_comb begin
    nxt_ch = out_ch;
    nxt_x  = out_x;
    nxt_y  = out_y;
    if (out_y == 4'(POOL_Y - 1)) begin
      nxt_y = '0;
      if (out_x == 4'(POOL_X - 1)) begin
        nxt_x  = '0;
        nxt_ch = out_ch + 3'd1;
      end else begin
        nxt_x = out_x + 4'd1;
      end
    end else begin
      nxt_y = out_y + 4'd1;
    end
  end

  // Stream controller; abort (pool_done dropped) takes priority over a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pool_done_q <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_valid   <= 1'b0;
      pool_hold   <= 1'b0;
      read_done   <= 1'b0;
      read_abort  <= 1'b0;
    end else begin
      pool_done_q <= pool_done;
      read_done   <= 1'b0;
      read_abort  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            out_ch    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_data  <= planes[0][0][0];
            out_valid <= 1'b1;
            pool_hold <= 1'b1;
          end
        end
        STREAM: begin
          if (!pool_done) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            pool_hold  <= 1'b0;
            read_abort <= 1'b1;
          end else if (handshake) begin
            if (at_end) begin
              state     <= DONE;
              out_valid <= 1'b0;
              pool_hold <= 1'b0;
              read_done <= 1'b1;
            end else begin
              out_ch   <= nxt_ch;
              out_x    <= nxt_x;
              out_y    <= nxt_y;
              out_data <= nxt_data;
            end
          end
        end
        DONE: begin
          state <= pool_done ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          if (!pool_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_stream_reader.sv
// Bench for pool_stream_reader: directed sequence with random data and random
// backpressure, checked against an ordered element list built from the planes.
module tb_pool_stream_reader;

  localparam int DW = 69;
  localparam int NX = 12;
  localparam int NY = 12;
  localparam int NC = 8;
  localparam int NTOT = NC * NX * NY;

  typedef struct {
    int            ch;
    int            x;
    int            y;
    logic [DW-1:0] val;
  } elem_t;

  logic                                clk;
  logic                                rst_n;
  logic                                pool_done;
  logic                                out_ready;
  logic [NX-1:0][NY-1:0][DW-1:0]       pr [NC];
  logic                                pool_hold;
  logic signed [DW-1:0]                out_data;
  logic [2:0]                          out_ch;
  logic [3:0]                          out_x;
  logic [3:0]                          out_y;
  logic                                out_valid;
  logic                                out_last;
  logic                                read_done;
  logic                                read_abort;

  int total;
  int bad;

  pool_stream_reader #(
    .DATA_WIDTH(DW),
    .POOL_X    (NX),
    .POOL_Y    (NY),
    .NUM_CH    (NC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pool_done    (pool_done),
    .pool_result_1(pr[0]),
    .pool_result_2(pr[1]),
    .pool_result_3(pr[2]),
    .pool_result_4(pr[3]),
    .pool_result_5(pr[4]),
    .pool_result_6(pr[5]),
    .pool_result_7(pr[6]),
    .pool_result_8(pr[7]),
    .pool_hold    (pool_hold),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .read_done    (read_done),
    .read_abort   (read_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < NC; k++)
      for (int x = 0; x < NX; x++)
        for (int y = 0; y < NY; y++)
          pr[k][x][y] = DW'((k + 1) * 1000 + x * 12 + y);
    pr[2][5][7] = '1;
  endtask

  task automatic fill_random();
    logic [95:0] r;
    for (int k = 0; k < NC; k++)
      for (int x = 0; x < NX; x++)
        for (int y = 0; y < NY; y++) begin
          r = {$urandom, $urandom, $urandom};
          pr[k][x][y] = r[DW-1:0];
        end
  endtask

  // Starts a stream from IDLE with pool_done low; leaves pool_done high on
  // normal completion and low after an abort.
  task automatic run_stream(input int ready_pct, input int abort_at, input bit check_neg);
    elem_t         q[$];
    elem_t         e;
    int            idx;
    int            hold_cnt;
    int            valid_cnt;
    int            abort_cnt;
    bit            finished;
    bit            stalled;
    logic [DW-1:0] held;
    logic [DW-1:0] neg_obs;

    for (int k = 0; k < NC; k++)
      for (int x = 0; x < NX; x++)
        for (int y = 0; y < NY; y++) begin
          e.ch = k; e.x = x; e.y = y; e.val = pr[k][x][y];
          q.push_back(e);
        end
    idx = 0; hold_cnt = 0; valid_cnt = 0; abort_cnt = 0;
    finished = 1'b0; stalled = 1'b0; held = '0; neg_obs = '0;

    pool_done = 1'b1;
    out_ready = 1'b0;
    step();
    chk("start_valid", out_valid, 1);
    chk("start_hold", pool_hold, 1);

    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      if (pool_hold) hold_cnt++;
      if (read_abort) abort_cnt++;
      if (out_valid) begin
        valid_cnt++;
        if (idx < NTOT) begin
          chk("data", out_data, q[idx].val);
          chk("ch", out_ch, q[idx].ch);
          chk("x", out_x, q[idx].x);
          chk("y", out_y, q[idx].y);
          chk("last", out_last, (idx == NTOT - 1));
          if (q[idx].ch == 2 && q[idx].x == 5 && q[idx].y == 7) neg_obs = out_data;
        end else begin
          chk("extra_valid", out_valid, 0);
        end
        if (stalled) chk("stall_hold", out_data, held);
      end
      if (read_done) begin
        finished = 1'b1;
        chk("done_count", idx, NTOT);
        chk("done_valid", out_valid, 0);
        chk("done_last", out_last, 0);
        chk("done_hold", pool_hold, 0);
        chk("no_abort", abort_cnt, 0);
        if (ready_pct >= 100) begin
          chk("done_latency", cyc, NTOT);
          chk("hold_cycles", hold_cnt, NTOT);
        end else begin
          chk("hold_cycles", hold_cnt, valid_cnt);
        end
        if (check_neg) chk("neg_value", neg_obs, {DW{1'b1}});
        step();
        chk("done_pulse", read_done, 0);
      end else if (abort_at >= 0 && idx == abort_at) begin
        finished = 1'b1;
        pool_done = 1'b0;
        out_ready = 1'b0;
        step();
        chk("abort_valid", out_valid, 0);
        chk("abort_hold", pool_hold, 0);
        chk("abort_pulse", read_abort, 1);
        chk("abort_no_done", read_done, 0);
        step();
        chk("abort_pulse_end", read_abort, 0);
        chk("abort_no_done2", read_done, 0);
        chk("abort_idle", out_valid, 0);
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
        stalled = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) idx++;
        step();
      end
    end
    if (!finished) chk("timeout", finished, 1);
  endtask

  initial begin
    int busy;
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    pool_done = 1'b0;
    out_ready = 1'b0;
    fill_pattern();

    // Reset asserted before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_hold", pool_hold, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", read_done, 0);
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_valid", out_valid, 0);
    chk("idle_hold", pool_hold, 0);
    chk("idle_data", out_data, 0);

    // Full stream, no backpressure, known pattern with a -1 element.
    run_stream(100, -1, 1'b1);

    // pool_done held high: no second stream.
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || pool_hold) busy++;
      step();
    end
    chk("no_retrigger", busy, 0);
    pool_done = 1'b0;
    step(); step();

    // Second stream after a fresh rising edge, random data, 50% backpressure.
    fill_random();
    run_stream(50, -1, 1'b0);
    pool_done = 1'b0;
    step(); step();

    // Abort after 200 handshakes, then restart from the first element.
    fill_random();
    run_stream(100, 200, 1'b0);
    step();
    run_stream(70, -1, 1'b0);
    pool_done = 1'b0;
    step(); step();

    // Asynchronous reset in the middle of a stream.
    pool_done = 1'b1;
    out_ready = 1'b1;
    step(); step(); step();
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_hold", pool_hold, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_ch", out_ch, 0);
    chk("mrst_x", out_x, 0);
    chk("mrst_y", out_y, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_done", read_done, 0);
    chk("mrst_abort", read_abort, 0);
    pool_done = 1'b0;
    step();
    rst_n = 1'b1;
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      if (read_done || read_abort || out_valid) busy++;
      step();
    end
    chk("mrst_no_pulse", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_stream_reader.md
# pool_stream_reader

Consumer-side reader for the max-pool stage output. When the pool stage signals completion it holds the pool stage's eight 12x12 result planes stable through a hold request. It then streams every element out one per handshake over a valid/ready interface to the downstream fully-connected layer, tagged with channel/row/column coordinates. Order is channel-major (channel 1 first), then row x, then column y.

## Interface
- DATA_WIDTH, 69, element width (signed), matches the pool stage result width
- POOL_X, 12, rows per plane
- POOL_Y, 12, columns per plane
- NUM_CH, 8, number of planes (fixed at 8 by port list; parameter used for counter bound)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pool_done  in  1  pool stage results valid and stable while high
- pool_result_1 .. pool_result_8  in  signed [DATA_WIDTH-1:0] [POOL_X-1:0][POOL_Y-1:0]  pool stage result planes
- pool_hold  out  1  request to upstream control to keep pool_enable asserted (planes stable) while high
- out_data  out  signed DATA_WIDTH  current element
- out_ch  out  3  plane index 0..7 (0 = pool_result_1)
- out_x  out  4  row index 0..POOL_X-1
- out_y  out  4  column index 0..POOL_Y-1
- out_valid  out  1  element on out_* is valid
- out_ready  in  1  downstream accepts element when out_valid && out_ready
- out_last  out  1  high with final element (ch 7, x 11, y 11)
- read_done  out  1  one-cycle pulse after final handshake
- read_abort  out  1  one-cycle pulse when stream aborted

## Operation
- States: IDLE, STREAM, DONE, WAIT_LOW.
- pool_done_q: registered copy of pool_done; start = pool_done && !pool_done_q.
- IDLE: on start -> STREAM; counters ch=x=y=0; out_data loaded with pool_result_1[0][0]; pool_hold set.
- STREAM: out_valid=1, pool_hold=1. On handshake: advance y; y wrap 11->0 advances x; x wrap 11->0 advances ch. out_data/out_ch/out_x/out_y reload with the next element in the same edge.
- out_last = out_valid && ch==NUM_CH-1 && x==POOL_X-1 && y==POOL_Y-1.
- Handshake with out_last -> DONE; counters not advanced past end.
- DONE: read_done=1 for exactly one cycle, pool_hold=0, out_valid=0; -> WAIT_LOW if pool_done still high, else IDLE.
- WAIT_LOW: waits for pool_done low -> IDLE. A level-high pool_done never re-triggers; one stream per pool_done rising edge.
- Abort: pool_done low while in STREAM (sampled at the edge) -> IDLE next cycle; out_valid, pool_hold drop; read_abort pulses one cycle; no read_done. Any handshake coinciding with the abort edge is discarded by downstream contract (do not rely on it).
- out_data is a registered copy; values held while out_valid && !out_ready (no change even if inputs change).
- No arithmetic; data passed bit-exact, sign preserved.

## Timing
- Reset (rst_n low, immediate): state IDLE, pool_done_q=0, all outputs 0 (out_data, out_ch, out_x, out_y, out_valid, out_last, pool_hold, read_done, read_abort).
- Start latency: pool_done rises before edge N -> out_valid and pool_hold high after edge N.
- Throughput: one element per cycle with out_ready held high; 1152 elements occupy cycles N+1..N+1152; read_done high in cycle N+1153.
- Backpressure: out_ready low stalls indefinitely; all out_* stable.
- Reset mid-stream: immediate return to reset values; no read_done/read_abort pulse.
- pool_done rising in DONE/WAIT_LOW: ignored until IDLE plus a fresh rising edge.

## Test plan
- Reset: rst_n low asynchronously mid-cycle -> all outputs 0 immediately; stay 0 with pool_done=0.
- Full stream: pool_result_k[x][y] = k*1000 + x*12 + y, out_ready=1, pulse pool_done high and hold -> 1152 elements in order, first (ch0,0,0)=1000, element 13 (ch0,1,0)=1012, last (ch7,11,11)=8143 with out_last; read_done one cycle later; pool_hold high exactly 1152 cycles.
- Negative values: pool_result_3[5][7] = -1 (all ones) -> out_data = all ones at (ch2,5,7), sign intact.
- Backpressure: out_ready random 50% -> same 1152-element sequence, no duplicates/drops; out_* stable on every stalled cycle.
- Abort: drop pool_done after 200 handshakes -> out_valid/pool_hold low next cycle, read_abort one pulse, no read_done; new pool_done rising edge restarts at (ch0,0,0).
- No retrigger: pool_done held high after read_done -> no second stream; lower then raise -> second full stream.
